eth_rx_dibit_asm: RTL and testbench
===================================

// Module: eth_rx_dibit_asm
// PURPOSE
//  RMII receive front end. Sits directly upstream of the RX byte-control FSM.
//  Detects preamble/SFD on Rxd qualified by Crs_Dv and packs LSB-first dibits into bytes.
//  Presents each byte as a one-cycle Byte_Rdy strobe plus Byte, together with frame
//  delimiters, a running byte count and error flags.
//  One dibit is accepted per Clk (50 MHz RMII, 100 Mb/s).
// PARAMETERS
//  pMax_Frame_Bytes  16'd1522  max bytes after SFD (DA through FCS); exceeding this raises Len_Err
//  pMax_Pre_Dibits   8'd32     max consecutive preamble dibits before the attempt is abandoned
// PORTS
//  Clk          in   1   RMII reference clock; all logic on posedge
//  Rst          in   1   reset, asynchronous assert, active-low (0 = reset)
//  Crs_Dv       in   1   PHY carrier-sense/data-valid
//  Rxd          in   2   PHY receive dibit
//  Byte_Rdy     out  1   1-cycle strobe: Byte valid
//  Byte         out  8   assembled byte; holds its value between strobes
//  Frame_Start  out  1   1-cycle strobe in the cycle after SFD is accepted
//  Frame_End    out  1   1-cycle strobe when a DATA frame terminates (any cause)
//  Byte_Cnt     out  16  bytes emitted in current/last frame
//  Align_Err    out  1   1-cycle strobe with Frame_End: frame ended on a partial byte
//  Len_Err      out  1   1-cycle strobe: byte count reached pMax_Frame_Bytes with Crs_Dv still high
// BEHAVIOUR
//  Reset (Rst=0, async)
//   - All outputs are 0, FSM is IDLE, and the shift register and counters are 0.
//   - Reset taken mid-frame aborts the frame with no Frame_End.
//  FSM states: IDLE(0), PREAMBLE(1), DATA(2), DROP(3).
//  IDLE
//   - Crs_Dv=1 && Rxd=01 -> PREAMBLE, preamble counter := 1.
//  PREAMBLE (Crs_Dv=1 required, else -> IDLE)
//   - Rxd=01: stay, counter++.
//   - Counter reaching pMax_Pre_Dibits -> IDLE.
//   - Rxd=11 -> DATA. Next cycle: Frame_Start=1, Byte_Cnt:=0, dibit index:=0.
//   - Rxd=00 or 10 -> IDLE (false carrier); no strobes.
//  DATA
//   - Each cycle with Crs_Dv=1: rShift <= {Rxd, rShift[7:2]}, dibit index++ (2-bit, wraps).
//   - On the 4th dibit (index==3):
//     - Byte <= {Rxd, rShift[7:2]}.
//     - Byte_Rdy=1 in the following cycle (1 clk latency from 4th dibit).
//     - Byte_Cnt++ in the same cycle as Byte_Rdy.
//   - Crs_Dv=0 with index==0: Frame_End=1 next cycle -> IDLE.
//   - Crs_Dv=0 with index!=0: partial byte discarded (no Byte_Rdy).
//     Frame_End=1 and Align_Err=1 in the same cycle -> IDLE.
//   - Byte_Cnt update making it == pMax_Frame_Bytes while Crs_Dv=1 (next dibit still valid):
//     Len_Err=1 and Frame_End=1 -> DROP. No further Byte_Rdy.
//   - Byte_Rdy for the final byte and Frame_End are never in the same cycle.
//     Frame_End is at least 1 cycle after the last Byte_Rdy.
//  DROP
//   - Ignore Rxd. Crs_Dv=0 -> IDLE.
//   - A new preamble is never detected before Crs_Dv has been low for at least 1 cycle.
//  Output hold rules
//   - Byte_Cnt holds after Frame_End until the next Frame_Start clears it.
//   - Byte_Cnt saturates at 16'hFFFF, which is unreachable given pMax_Frame_Bytes.
//  Strobe widths
//   - Frame_Start, Frame_End, Byte_Rdy, Align_Err and Len_Err are exactly 1 cycle wide.
//   - Back-to-back bytes produce Byte_Rdy every 4th cycle.
// TESTING
//  T1 Reset
//   - Hold Rst=0 with random Crs_Dv/Rxd -> all outputs 0.
//   - Release Rst -> outputs stay 0 until a valid preamble arrives.
//  T2 Nominal frame
//   - Stimulus: 7x 0x55 + 0xD5 (dibits LSB first), then bytes 0x12, 0x34, 0xA5; drop Crs_Dv.
//   - Frame_Start 1 cycle after SFD.
//   - Byte_Rdy x3 with Byte=0x12, 0x34, 0xA5, spaced 4 cycles apart.
//   - Frame_End then fires; Byte_Cnt=3; no error strobes.
//  T3 Dibit order
//   - Byte 0xA5 sent as Rxd 01,01,10,10 -> Byte=0xA5, not 0x5A.
//  T4 Partial byte
//   - Nominal frame of 2 bytes + 2 extra dibits, then Crs_Dv=0.
//   - Exactly 2 Byte_Rdy; Frame_End and Align_Err high in the same cycle; Byte_Cnt=2.
//  T5 False carrier / long preamble
//   - Rxd=10 mid-preamble -> no Frame_Start, FSM returns to IDLE.
//   - 40 dibits of 01 with pMax_Pre_Dibits=32 -> no Frame_Start.
//  T6 Over-length and reset mid-frame
//   - pMax_Frame_Bytes=8, send 10 bytes -> 8 Byte_Rdy, then Len_Err+Frame_End; no further bytes.
//   - Assert Rst during byte 3 of a frame -> outputs 0 immediately.
//   - A following frame is received correctly.

Source files
------------

// File: rtl/eth_rx_dibit_asm_if.sv
// RMII receive-side bundle between the PHY dibit stream, the dibit assembler
// and the downstream byte-control FSM.
// master: the assembler, which consumes PHY dibits and sources bytes/delimiters.
// slave:  the surroundings, which drive the PHY dibits and consume the byte stream.
interface eth_rx_dibit_asm_if;
    logic        Crs_Dv;
    logic [1:0]  Rxd;
    logic        Byte_Rdy;
    logic [7:0]  Byte;
    logic        Frame_Start;
    logic        Frame_End;
    logic [15:0] Byte_Cnt;
    logic        Align_Err;
    logic        Len_Err;

    modport master (
        input  Crs_Dv,
        input  Rxd,
        output Byte_Rdy,
        output Byte,
        output Frame_Start,
        output Frame_End,
        output Byte_Cnt,
        output Align_Err,
        output Len_Err
    );

    modport slave (
        output Crs_Dv,
        output Rxd,
        input  Byte_Rdy,
        input  Byte,
        input  Frame_Start,
        input  Frame_End,
        input  Byte_Cnt,
        input  Align_Err,
        input  Len_Err
    );
endinterface

// File: rtl/eth_rx_dibit_asm.sv
// RMII receive front end: finds preamble/SFD on Rxd (qualified by Crs_Dv),
// packs LSB-first dibits into bytes and reports frame delimiters, a running
// byte count and alignment/length errors. All outputs are registered, so each
// strobe appears in the cycle after the dibit that caused it.
module eth_rx_dibit_asm #(
    parameter logic [15:0] pMax_Frame_Bytes = 16'd1522,
    parameter logic [7:0]  pMax_Pre_Dibits  = 8'd32
) (
    input logic                Clk,
    input logic                Rst,
    eth_rx_dibit_asm_if.master rx
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rxStateT;

    rxStateT     state;
    rxStateT     nextState;

    logic [7:0]  preCnt;
    logic [7:0]  shiftReg;
    logic [1:0]  dibitIdx;
    logic [7:0]  byteReg;
    logic [15:0] byteCnt;
    logic        byteRdy;
    logic        frameStart;
    logic        frameEnd;
    logic        alignErr;
    logic        lenErr;

    logic [7:0]  nextPreCnt;
    logic [7:0]  nextShift;
    logic [1:0]  nextIdx;
    logic [7:0]  nextByte;
    logic [15:0] nextByteCnt;
    logic        nextByteRdy;
    logic        nextFrameStart;
    logic        nextFrameEnd;
    logic        nextAlignErr;
    logic        nextLenErr;

    logic        crsDv;
    logic [1:0]  rxd;

    assign crsDv = rx.Crs_Dv;
    assign rxd   = rx.Rxd;

    // Next-state and next-output decode; strobes default low so each lasts one cycle.
    always_comb begin
        nextState      = state;
        nextPreCnt     = preCnt;
        nextShift      = shiftReg;
        nextIdx        = dibitIdx;
        nextByte       = byteReg;
        nextByteCnt    = byteCnt;
        nextByteRdy    = 1'b0;
        nextFrameStart = 1'b0;
        nextFrameEnd   = 1'b0;
        nextAlignErr   = 1'b0;
        nextLenErr     = 1'b0;

        case (state)
            IDLE: begin
                if (crsDv && (rxd == 2'b01)) begin
                    nextState  = PREAMBLE;
                    nextPreCnt = 8'd1;
                end
            end

            PREAMBLE: begin
                if (!crsDv) begin
                    nextState  = IDLE;
                    nextPreCnt = 8'd0;
                end else begin
                    case (rxd)
                        2'b01: begin
                            // A preamble that never ends is abandoned once it reaches the limit.
                            if ((preCnt + 8'd1) >= pMax_Pre_Dibits) begin
                                nextState  = IDLE;
                                nextPreCnt = 8'd0;
                            end else begin
                                nextPreCnt = preCnt + 8'd1;
                            end
                        end
                        2'b11: begin
                            nextState      = DATA;
                            nextPreCnt     = 8'd0;
                            nextFrameStart = 1'b1;
                            nextByteCnt    = 16'd0;
                            nextIdx        = 2'd0;
                            nextShift      = 8'd0;
                        end
                        default: begin
                            nextState  = IDLE;
                            nextPreCnt = 8'd0;
                        end
                    endcase
                end
            end

            DATA: begin
                if (!crsDv) begin
                    // Carrier gone: a non-zero dibit index means a partial byte is thrown away.
                    nextState    = IDLE;
                    nextFrameEnd = 1'b1;
                    nextAlignErr = (dibitIdx != 2'd0);
                    nextIdx      = 2'd0;
                    nextShift    = 8'd0;
                end else if (byteCnt == pMax_Frame_Bytes) begin
                    // Frame already at its maximum and still more data arriving.
                    nextState    = DROP;
                    nextLenErr   = 1'b1;
                    nextFrameEnd = 1'b1;
                    nextIdx      = 2'd0;
                    nextShift    = 8'd0;
                end else begin
                    nextShift = {rxd, shiftReg[7:2]};
                    nextIdx   = dibitIdx + 2'd1;
                    if (dibitIdx == 2'd3) begin
                        nextByte    = {rxd, shiftReg[7:2]};
                        nextByteRdy = 1'b1;
                        if (byteCnt != 16'hFFFF) begin
                            nextByteCnt = byteCnt + 16'd1;
                        end
                    end
                end
            end

            DROP: begin
                if (!crsDv) begin
                    nextState = IDLE;
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Datapath, counters and registered output strobes.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            preCnt     <= 8'd0;
            shiftReg   <= 8'd0;
            dibitIdx   <= 2'd0;
            byteReg    <= 8'd0;
            byteCnt    <= 16'd0;
            byteRdy    <= 1'b0;
            frameStart <= 1'b0;
            frameEnd   <= 1'b0;
            alignErr   <= 1'b0;
            lenErr     <= 1'b0;
        end else begin
            preCnt     <= nextPreCnt;
            shiftReg   <= nextShift;
            dibitIdx   <= nextIdx;
            byteReg    <= nextByte;
            byteCnt    <= nextByteCnt;
            byteRdy    <= nextByteRdy;
            frameStart <= nextFrameStart;
            frameEnd   <= nextFrameEnd;
            alignErr   <= nextAlignErr;
            lenErr     <= nextLenErr;
        end
    end

    assign rx.Byte_Rdy    = byteRdy;
    assign rx.Byte        = byteReg;
    assign rx.Frame_Start = frameStart;
    assign rx.Frame_End   = frameEnd;
    assign rx.Byte_Cnt    = byteCnt;
    assign rx.Align_Err   = alignErr;
    assign rx.Len_Err     = lenErr;

endmodule

// File: tb/tb_eth_rx_dibit_asm.sv
// Directed bench for the RMII dibit assembler. The DUT runs with an 8-byte
// frame limit so the over-length case stays short. A negedge monitor logs
// every strobe with the posedge number that produced it; the linear stimulus
// below compares those logs against hand-computed values.
module tb_eth_rx_dibit_asm;

    logic Clk = 1'b0;
    logic Rst;

    eth_rx_dibit_asm_if rxIf();

    eth_rx_dibit_asm #(
        .pMax_Frame_Bytes(16'd8),
        .pMax_Pre_Dibits (8'd32)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .rx (rxIf.master)
    );

    // 50 MHz RMII reference clock.
    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rdyBytes[$];
    int         rdyCyc[$];
    int fsCount = 0;
    int fsCyc   = 0;
    int feCount = 0;
    int feCyc   = 0;
    int aeCount = 0;
    int aeCyc   = 0;
    int leCount = 0;
    int leCyc   = 0;
    int wideCnt = 0;
    logic prevRdy = 1'b0;
    logic prevFs  = 1'b0;
    logic prevFe  = 1'b0;
    logic prevAe  = 1'b0;
    logic prevLe  = 1'b0;

    int rdy0, fs0, fe0, ae0, le0;
    int sfdCyc, endCyc;

    // Posedge counter used to timestamp strobes.
    always @(posedge Clk) cyc <= cyc + 1;

    // Strobe logger: records each strobe and flags any strobe held for two cycles.
    always @(negedge Clk) begin
        if (rxIf.Byte_Rdy) begin
            rdyBytes.push_back(rxIf.Byte);
            rdyCyc.push_back(cyc);
        end
        if (rxIf.Frame_Start) begin fsCount++; fsCyc = cyc; end
        if (rxIf.Frame_End)   begin feCount++; feCyc = cyc; end
        if (rxIf.Align_Err)   begin aeCount++; aeCyc = cyc; end
        if (rxIf.Len_Err)     begin leCount++; leCyc = cyc; end
        if ((rxIf.Byte_Rdy && prevRdy) || (rxIf.Frame_Start && prevFs) ||
            (rxIf.Frame_End && prevFe) || (rxIf.Align_Err && prevAe) ||
            (rxIf.Len_Err && prevLe)) begin
            wideCnt++;
        end
        prevRdy = rxIf.Byte_Rdy;
        prevFs  = rxIf.Frame_Start;
        prevFe  = rxIf.Frame_End;
        prevAe  = rxIf.Align_Err;
        prevLe  = rxIf.Len_Err;
    end

    function automatic logic [31:0] outBundle();
        return {3'b000, rxIf.Byte_Rdy, rxIf.Byte, rxIf.Frame_Start, rxIf.Frame_End,
                rxIf.Byte_Cnt, rxIf.Align_Err, rxIf.Len_Err};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one dibit for exactly one clock; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic cd, input logic [1:0] d);
        rxIf.Crs_Dv = cd;
        rxIf.Rxd    = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b[1:0]);
        applyStimulus(1'b1, b[3:2]);
        applyStimulus(1'b1, b[5:4]);
        applyStimulus(1'b1, b[7:6]);
    endtask

    // 7x 0x55 then 0xD5: 31 dibits of 01 followed by the 11 SFD dibit.
    task automatic sendPreamble();
        repeat (7) sendByte(8'h55);
        sendByte(8'hD5);
        sfdCyc = cyc;
    endtask

    task automatic takeSnapshot();
        rdy0 = rdyBytes.size();
        fs0  = fsCount;
        fe0  = feCount;
        ae0  = aeCount;
        le0  = leCount;
    endtask

    initial begin
        Rst         = 1'b0;
        rxIf.Crs_Dv = 1'b0;
        rxIf.Rxd    = 2'b00;

        $display("[TB] T1 reset");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            checkOutput("t1_in_reset", outBundle(), 32'd0);
        end
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b01);
            checkOutput("t1_idle_no_crs", outBundle(), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b11);
            checkOutput("t1_idle_no_preamble", outBundle(), 32'd0);
        end
        applyStimulus(1'b0, 2'b00);

        $display("[TB] T2 nominal frame");
        takeSnapshot();
        sendPreamble();
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'hA5);
        applyStimulus(1'b0, 2'b00);
        endCyc = cyc;
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t2_fs_count", fsCount - fs0, 1);
        checkOutput("t2_fs_cycle", fsCyc - sfdCyc, 0);
        checkOutput("t2_rdy_count", rdyBytes.size() - rdy0, 3);
        checkOutput("t2_byte0", 32'(rdyBytes[rdy0]), 32'h12);
        checkOutput("t2_byte1", 32'(rdyBytes[rdy0 + 1]), 32'h34);
        checkOutput("t2_byte2", 32'(rdyBytes[rdy0 + 2]), 32'hA5);
        checkOutput("t2_rdy0_cycle", rdyCyc[rdy0] - sfdCyc, 4);
        checkOutput("t2_rdy1_cycle", rdyCyc[rdy0 + 1] - sfdCyc, 8);
        checkOutput("t2_rdy2_cycle", rdyCyc[rdy0 + 2] - sfdCyc, 12);
        checkOutput("t2_fe_count", feCount - fe0, 1);
        checkOutput("t2_fe_cycle", feCyc - sfdCyc, 13);
        checkOutput("t2_fe_vs_end", feCyc - endCyc, 0);
        checkOutput("t2_byte_cnt", 32'(rxIf.Byte_Cnt), 32'd3);
        checkOutput("t2_byte_hold", 32'(rxIf.Byte), 32'hA5);
        checkOutput("t2_no_errs", (aeCount - ae0) + (leCount - le0), 0);

        $display("[TB] T3 dibit order");
        takeSnapshot();
        sendPreamble();
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b10);
        applyStimulus(1'b1, 2'b10);
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t3_rdy_count", rdyBytes.size() - rdy0, 1);
        checkOutput("t3_byte", 32'(rdyBytes[rdy0]), 32'hA5);
        checkOutput("t3_byte_cnt", 32'(rxIf.Byte_Cnt), 32'd1);
        checkOutput("t3_no_align", aeCount - ae0, 0);

        $display("[TB] T4 partial byte");
        takeSnapshot();
        sendPreamble();
        sendByte(8'h3C);
        sendByte(8'hC3);
        applyStimulus(1'b1, 2'b10);
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b0, 2'b00);
        endCyc = cyc;
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t4_rdy_count", rdyBytes.size() - rdy0, 2);
        checkOutput("t4_byte0", 32'(rdyBytes[rdy0]), 32'h3C);
        checkOutput("t4_byte1", 32'(rdyBytes[rdy0 + 1]), 32'hC3);
        checkOutput("t4_fe_count", feCount - fe0, 1);
        checkOutput("t4_ae_count", aeCount - ae0, 1);
        checkOutput("t4_fe_cycle", feCyc - endCyc, 0);
        checkOutput("t4_ae_cycle", aeCyc - endCyc, 0);
        checkOutput("t4_byte_cnt", 32'(rxIf.Byte_Cnt), 32'd2);
        checkOutput("t4_byte_hold", 32'(rxIf.Byte), 32'hC3);

        $display("[TB] T5 false carrier and long preamble");
        takeSnapshot();
        repeat (10) applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b10);
        repeat (6) applyStimulus(1'b1, 2'b11);
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t5_false_fs", fsCount - fs0, 0);
        checkOutput("t5_false_fe", feCount - fe0, 0);
        checkOutput("t5_false_rdy", rdyBytes.size() - rdy0, 0);
        takeSnapshot();
        repeat (40) applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t5_long40_fs", fsCount - fs0, 0);
        takeSnapshot();
        repeat (32) applyStimulus(1'b1, 2'b01);
        repeat (9) applyStimulus(1'b1, 2'b11);
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t5_long32_fs", fsCount - fs0, 0);
        checkOutput("t5_long32_rdy", rdyBytes.size() - rdy0, 0);

        $display("[TB] T6 over-length");
        takeSnapshot();
        sendPreamble();
        for (int b = 1; b <= 10; b++) sendByte(8'(b));
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t6_rdy_count", rdyBytes.size() - rdy0, 8);
        checkOutput("t6_first_byte", 32'(rdyBytes[rdy0]), 32'h01);
        checkOutput("t6_last_byte", 32'(rdyBytes[rdy0 + 7]), 32'h08);
        checkOutput("t6_last_rdy_cycle", rdyCyc[rdy0 + 7] - sfdCyc, 32);
        checkOutput("t6_le_count", leCount - le0, 1);
        checkOutput("t6_fe_count", feCount - fe0, 1);
        checkOutput("t6_le_cycle", leCyc - sfdCyc, 33);
        checkOutput("t6_fe_cycle", feCyc - sfdCyc, 33);
        checkOutput("t6_byte_cnt", 32'(rxIf.Byte_Cnt), 32'd8);
        checkOutput("t6_no_align", aeCount - ae0, 0);

        $display("[TB] T6 reset mid-frame");
        takeSnapshot();
        sendPreamble();
        sendByte(8'hC9);
        sendByte(8'hE1);
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b10);
        checkOutput("t6_pre_rst_cnt", 32'(rxIf.Byte_Cnt), 32'd2);
        Rst         = 1'b0;
        rxIf.Crs_Dv = 1'b0;
        #1;
        checkOutput("t6_rst_outputs", outBundle(), 32'd0);
        repeat (2) applyStimulus(1'b0, 2'b00);
        Rst = 1'b1;
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t6_rst_no_fe", feCount - fe0, 0);
        takeSnapshot();
        sendPreamble();
        sendByte(8'h5A);
        sendByte(8'h77);
        applyStimulus(1'b0, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("t6_after_rdy", rdyBytes.size() - rdy0, 2);
        checkOutput("t6_after_byte0", 32'(rdyBytes[rdy0]), 32'h5A);
        checkOutput("t6_after_byte1", 32'(rdyBytes[rdy0 + 1]), 32'h77);
        checkOutput("t6_after_cnt", 32'(rxIf.Byte_Cnt), 32'd2);
        checkOutput("t6_after_fe", feCount - fe0, 1);

        checkOutput("strobe_width", wideCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
